io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder_pkg.sv | 28 ++
 rtl/debounce_botao.sv | 44 ++++
 rtl/io_responder.sv | 153 +++++++++++++++
 tb/tb_io_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// Shared types and constants for io_responder: FSM state encoding and the binary-to-BCD step.
// CONVERT exists only when IO_RESPONDER_BCD_EN is defined.
package io_responder_pkg;

    localparam int BCD_ITERS   = 14;
    localparam int MAX_DISPLAY = 9999;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
`ifdef IO_RESPONDER_BCD_EN
        CONVERT      = 3'd1,
`endif
        WAIT_PRESS   = 3'd2,
        WAIT_RELEASE = 3'd3,
        WAIT_DROP    = 3'd4
    } state_t;

    // Add-3 correction applied to every BCD nibble of 5 or more before each shift.
    function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchronizer plus debouncer for the active-low confirm button.
// The pressed output changes only after DEBOUNCE_CYCLES consecutive samples disagree with it.
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic srst,
    input  logic botao,
    output logic pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;
    logic          pressed_reg;
    logic          sample_pressed;

    assign sample_pressed = ~sync2_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            cnt_reg     <= '0;
            pressed_reg <= 1'b0;
        end else begin
            sync1_reg <= botao;
            sync2_reg <= sync1_reg;
            if (sample_pressed == pressed_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                pressed_reg <= sample_pressed;
                cnt_reg     <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign pressed = pressed_reg;

endmodule

// File: rtl/io_responder.sv
// Operator I/O responder: freezes the processor during IN/OUT, captures switches, drives digits.
// Define IO_RESPONDER_BCD_EN for decimal display via CONVERT; otherwise digits show hex.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int IN_WIDTH        = 14
) (
    input  logic                clock_fpga,
    input  logic                reset,
    input  logic                req_in,
    input  logic                req_out,
    input  logic [31:0]         out_data,
    input  logic [7:0]          switches,
    input  logic                botao,
    output logic                congela,
    output logic [IN_WIDTH-1:0] in_data,
    output logic                in_valid,
    output logic [3:0]          dig0,
    output logic [3:0]          dig1,
    output logic [3:0]          dig2,
    output logic [3:0]          dig3
);

    state_t              state_reg;
    logic                is_in_reg;
    logic                pressed;
    logic                pressed_prev_reg;
    logic                press_evt;
    logic                congela_reg;
    logic [IN_WIDTH-1:0] in_data_reg;
    logic                in_valid_reg;
    logic [3:0]          dig_reg [4];

    debounce_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clock_fpga),
        .srst   (reset),
        .botao  (botao),
        .pressed(pressed)
    );

    // Only a fresh press counts, so a button already held on entry is ignored.
    assign press_evt = pressed & ~pressed_prev_reg;

`ifdef IO_RESPONDER_BCD_EN
    logic [13:0] clamped;
    logic [13:0] bin_reg;
    logic [15:0] bcd_reg;
    logic [15:0] bcd_adj;
    logic [15:0] bcd_shift;
    logic [3:0]  iter_reg;
    logic        unused_bits;

    assign clamped     = (out_data[13:0] > 14'(MAX_DISPLAY)) ? 14'(MAX_DISPLAY) : out_data[13:0];
    assign bcd_adj     = bcd_add3(bcd_reg);
    assign bcd_shift   = {bcd_adj[14:0], bin_reg[13]};
    assign unused_bits = ^out_data[31:14];
`else
    logic unused_bits;
    assign unused_bits = ^out_data[31:16];
`endif

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            state_reg        <= IDLE;
            is_in_reg        <= 1'b0;
            pressed_prev_reg <= 1'b0;
            congela_reg      <= 1'b0;
            in_data_reg      <= '0;
            in_valid_reg     <= 1'b0;
            dig_reg          <= '{default: '0};
`ifdef IO_RESPONDER_BCD_EN
            bin_reg          <= '0;
            bcd_reg          <= '0;
            iter_reg         <= '0;
`endif
        end else begin
            pressed_prev_reg <= pressed;
            in_valid_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    congela_reg <= 1'b0;
                    if (req_out) begin
                        is_in_reg   <= 1'b0;
                        congela_reg <= 1'b1;
`ifdef IO_RESPONDER_BCD_EN
                        bin_reg     <= clamped;
                        bcd_reg     <= '0;
                        iter_reg    <= '0;
                        state_reg   <= CONVERT;
`else
                        dig_reg[0]  <= out_data[3:0];
                        dig_reg[1]  <= out_data[7:4];
                        dig_reg[2]  <= out_data[11:8];
                        dig_reg[3]  <= out_data[15:12];
                        state_reg   <= WAIT_PRESS;
`endif
                    end else if (req_in) begin
                        is_in_reg   <= 1'b1;
                        congela_reg <= 1'b1;
                        state_reg   <= WAIT_PRESS;
                    end
                end
`ifdef IO_RESPONDER_BCD_EN
                CONVERT: begin
                    bcd_reg  <= bcd_shift;
                    bin_reg  <= {bin_reg[12:0], 1'b0};
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'(BCD_ITERS - 1)) begin
                        dig_reg[0] <= bcd_shift[3:0];
                        dig_reg[1] <= bcd_shift[7:4];
                        dig_reg[2] <= bcd_shift[11:8];
                        dig_reg[3] <= bcd_shift[15:12];
                        state_reg  <= WAIT_PRESS;
                    end
                end
`endif
                WAIT_PRESS: begin
                    if (press_evt) begin
                        state_reg <= WAIT_RELEASE;
                        if (is_in_reg) begin
                            in_data_reg  <= IN_WIDTH'(switches);
                            in_valid_reg <= 1'b1;
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (!pressed) begin
                        congela_reg <= 1'b0;
                        state_reg   <= WAIT_DROP;
                    end
                end
                WAIT_DROP: begin
                    if (!req_in && !req_out) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign congela  = congela_reg;
    assign in_data  = in_data_reg;
    assign in_valid = in_valid_reg;
    assign dig0     = dig_reg[0];
    assign dig1     = dig_reg[1];
    assign dig2     = dig_reg[2];
    assign dig3     = dig_reg[3];

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder with a short debounce; follows IO_RESPONDER_BCD_EN.
module tb_io_responder;

    localparam int DB        = 4;
    localparam int SETTLE    = DB + 6;
    localparam int CONV_WAIT = 18;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_in = 1'b0;
    logic        req_out = 1'b0;
    logic [31:0] out_data = '0;
    logic [7:0]  switches = '0;
    logic        botao = 1'b1;
    logic        congela;
    logic [13:0] in_data;
    logic        in_valid;
    logic [3:0]  dig0, dig1, dig2, dig3;

    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    logic [15:0] exp_digits = '0;

    io_responder #(
        .DEBOUNCE_CYCLES(DB),
        .IN_WIDTH(14)
    ) dut (
        .clock_fpga(clk),
        .reset     (reset),
        .req_in    (req_in),
        .req_out   (req_out),
        .out_data  (out_data),
        .switches  (switches),
        .botao     (botao),
        .congela   (congela),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .dig0      (dig0),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_valid) pulses <= pulses + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn();
        botao = 1'b0;
        tick(SETTLE);
    endtask

    task automatic release_btn();
        botao = 1'b1;
        tick(SETTLE);
    endtask

    // Reference display value: decimal of the clamped low 14 bits, or the raw low 16 bits in hex.
    function automatic logic [15:0] model_digits(input logic [31:0] d);
`ifdef IO_RESPONDER_BCD_EN
        int v;
        v = int'(d[13:0]);
        if (v > 9999) v = 9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
        return d[15:0];
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({congela, in_valid, in_data, dig3, dig2, dig1, dig0} !== '0)
            $display("FAIL reset_state: got c=%b v=%b in=%h dig=%h, expected all zero",
                     congela, in_valid, in_data, {dig3, dig2, dig1, dig0});
        reset = 1'b0;
        tick(2);
        checks++;
        if (congela !== 1'b0)
            $display("FAIL reset_idle: congela=%b expected 0", congela);
        exp_digits = '0;
    endtask

    task automatic test_out(input logic [31:0] d, input bit both, input bit hold);
        int p0;
        logic [15:0] prev;
        p0 = pulses;
        prev = exp_digits;
        out_data = d;
        req_out = 1'b1;
        req_in = both;
        switches = 8'($urandom);
        checks++;
        if (congela !== 1'b0) begin errors++; $display("FAIL out_idle_congela: got %b expected 0", congela); end
        tick(1);
        checks++;
        if (congela !== 1'b1) begin errors++; $display("FAIL out_congela_rise: got %b expected 1", congela); end
        exp_digits = model_digits(d);
`ifdef IO_RESPONDER_BCD_EN
        checks++;
        if ({dig3, dig2, dig1, dig0} !== prev) begin
            errors++;
            $display("FAIL out_digits_during_convert: got %h expected %h", {dig3, dig2, dig1, dig0}, prev);
        end
`else
        checks++;
        if ({dig3, dig2, dig1, dig0} !== exp_digits) begin
            errors++;
            $display("FAIL out_hex_immediate: got %h expected %h (prev %h)", {dig3, dig2, dig1, dig0}, exp_digits, prev);
        end
`endif
        tick(CONV_WAIT);
        checks++;
        if ({dig3, dig2, dig1, dig0} !== exp_digits) begin
            errors++;
            $display("FAIL out_digits d=%h: got %h expected %h", d, {dig3, dig2, dig1, dig0}, exp_digits);
        end
        checks++;
        if (congela !== 1'b1) begin errors++; $display("FAIL out_wait_press_congela: got %b expected 1", congela); end
        press_btn();
        checks++;
        if (congela !== 1'b1) begin errors++; $display("FAIL out_held_congela: got %b expected 1", congela); end
        release_btn();
        checks++;
        if (congela !== 1'b0) begin errors++; $display("FAIL out_release_congela: got %b expected 0", congela); end
        if (hold) begin
            tick(12);
            checks++;
            if (congela !== 1'b0) begin errors++; $display("FAIL out_wait_drop_hold: got %b expected 0", congela); end
        end
        req_out = 1'b0;
        req_in = 1'b0;
        tick(2);
        checks++;
        if (pulses !== p0) begin errors++; $display("FAIL out_no_in_valid: got %0d pulses expected 0", pulses - p0); end
        $display("OUT d=%h both=%0b digits=%h", d, both, {dig3, dig2, dig1, dig0});
    endtask

    task automatic test_in(input logic [7:0] sw);
        int p0;
        p0 = pulses;
        req_in = 1'b1;
        switches = sw;
        out_data = $urandom;
        tick(1);
        checks++;
        if (congela !== 1'b1) begin errors++; $display("FAIL in_congela_rise: got %b expected 1", congela); end
        press_btn();
        checks++;
        if (pulses !== p0 + 1) begin errors++; $display("FAIL in_valid_count: got %0d expected 1", pulses - p0); end
        checks++;
        if (in_data !== {6'b0, sw}) begin errors++; $display("FAIL in_data: got %h expected %h", in_data, {6'b0, sw}); end
        checks++;
        if ({dig3, dig2, dig1, dig0} !== exp_digits) begin
            errors++;
            $display("FAIL in_digits_unchanged: got %h expected %h", {dig3, dig2, dig1, dig0}, exp_digits);
        end
        release_btn();
        checks++;
        if (congela !== 1'b0) begin errors++; $display("FAIL in_release_congela: got %b expected 0", congela); end
        req_in = 1'b0;
        tick(2);
        $display("IN sw=%h in_data=%h", sw, in_data);
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        req_in = 1'b1;
        switches = 8'h3C;
        tick(1);
        repeat (4) begin
            botao = 1'b0;
            tick(3);
            botao = 1'b1;
            tick(5);
        end
        checks++;
        if (congela !== 1'b1 || pulses !== p0) begin
            errors++;
            $display("FAIL bounce_ignored: congela=%b pulses=%0d expected 1 and 0", congela, pulses - p0);
        end
        press_btn();
        release_btn();
        req_in = 1'b0;
        tick(2);
        checks++;
        if (pulses !== p0 + 1 || in_data !== 14'h003C) begin
            errors++;
            $display("FAIL bounce_then_press: pulses=%0d in_data=%h expected 1 and 003c", pulses - p0, in_data);
        end
        $display("BOUNCE in_data=%h", in_data);
    endtask

    task automatic test_press_in_idle();
        int p0;
        p0 = pulses;
        press_btn();
        req_in = 1'b1;
        switches = 8'h81;
        tick(12);
        checks++;
        if (congela !== 1'b1 || pulses !== p0) begin
            errors++;
            $display("FAIL held_press_ignored: congela=%b pulses=%0d expected 1 and 0", congela, pulses - p0);
        end
        release_btn();
        checks++;
        if (congela !== 1'b1) begin errors++; $display("FAIL held_release_still_waiting: got %b expected 1", congela); end
        press_btn();
        release_btn();
        req_in = 1'b0;
        tick(2);
        checks++;
        if (pulses !== p0 + 1 || in_data !== 14'h0081) begin
            errors++;
            $display("FAIL held_then_fresh_press: pulses=%0d in_data=%h expected 1 and 0081", pulses - p0, in_data);
        end
        $display("PRESS_IDLE in_data=%h", in_data);
    endtask

    task automatic test_reset_mid();
        req_in = 1'b1;
        switches = 8'h5A;
        tick(2);
        checks++;
        if (congela !== 1'b1) begin errors++; $display("FAIL reset_mid_pre: congela=%b expected 1", congela); end
        reset = 1'b1;
        tick(1);
        checks++;
        if ({congela, in_valid, in_data, dig3, dig2, dig1, dig0} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got c=%b v=%b in=%h dig=%h expected all zero",
                     congela, in_valid, in_data, {dig3, dig2, dig1, dig0});
        end
        reset = 1'b0;
        req_in = 1'b0;
        exp_digits = '0;
        tick(2);
        $display("RESET_MID congela=%b", congela);
    endtask

    initial begin
        test_reset();
        test_out(32'd1234, 1'b0, 1'b0);
        test_in(8'hA5);
        test_out(32'h0000_3FFF, 1'b0, 1'b0);
        test_bounce();
        test_out(32'h0000_BEEF, 1'b1, 1'b1);
        test_press_in_idle();
        test_in(8'h7E);
        test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1, 0) == 1) test_out($urandom, 1'($urandom_range(1, 0)), 1'b0);
            else test_in(8'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
